// File: rtl/output_sequencer.sv
// Feeds the result-file writer: buffers upstream words and slices them into NUM_FILES files.
// Build option OUT_CHECKSUM_EN appends an XOR checksum word to every file.
module output_sequencer #(
  parameter int DATA_W         = 25,
  parameter int IDX_W          = 10,
  parameter int WORDS_PER_FILE = 16,
  parameter int NUM_FILES      = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              write,
  output logic [DATA_W-1:0] data_out,
  output logic [IDX_W-1:0]  index,
  output logic              load_next_file,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (WORDS_PER_FILE > 1) ? $clog2(WORDS_PER_FILE) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_FILE - 1);
  localparam logic [IDX_W-1:0] LAST_FILE = IDX_W'(NUM_FILES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
`ifdef OUT_CHECKSUM_EN
  localparam logic [2:0] S_CSUM   = 3'd3;
`endif
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0] state, state_nx;
  logic [CNT_W-1:0] word_cnt;

  // Upstream handshake: a word transfers on any posedge where in_valid && in_ready.
  // in_ready only reflects FIFO space; a full FIFO never accepts, even if it pops that cycle.
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full, push, pop;
  logic [DATA_W-1:0] rd_data;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = rst && !fifo_full;
  assign push       = in_valid && in_ready;
  assign pop        = (state == S_STREAM) && !fifo_empty;
  assign rd_data    = mem[rd_ptr[AW-1:0]];
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LOAD;
      S_LOAD:   state_nx = S_STREAM;
      S_STREAM: begin
        if (pop && word_cnt == LAST_WORD) begin
`ifdef OUT_CHECKSUM_EN
          state_nx = S_CSUM;
`else
          state_nx = S_NEXT;
`endif
        end
      end
`ifdef OUT_CHECKSUM_EN
      S_CSUM:   state_nx = S_NEXT;
`endif
      S_NEXT:   state_nx = (index == LAST_FILE) ? S_DONE : S_LOAD;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

`ifdef OUT_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  // Accumulated at pop time, so it already covers the last data word when CSUM is entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      csum <= '0;
    end else if (state == S_LOAD) begin
      csum <= '0;
    end else if (pop) begin
      csum <= csum ^ rd_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      word_cnt       <= '0;
      index          <= '0;
      write          <= 1'b0;
      data_out       <= '0;
      load_next_file <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nx;
      busy           <= (state_nx != S_IDLE);
      load_next_file <= (state_nx == S_LOAD);
      done           <= (state_nx == S_DONE);
`ifdef OUT_CHECKSUM_EN
      write          <= pop || (state == S_CSUM);
      if (pop) data_out <= rd_data;
      else if (state == S_CSUM) data_out <= csum;
`else
      write          <= pop;
      if (pop) data_out <= rd_data;
`endif
      if (state == S_IDLE && start) begin
        index    <= '0;
        word_cnt <= '0;
      end
      if (pop) word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
      if (state == S_NEXT && index != LAST_FILE) index <= index + 1'b1;
    end
  end

endmodule

// File: tb/tb_output_sequencer.sv
// Directed bench for output_sequencer with 4 words/file, 2 files, 8-entry FIFO.
module tb_output_sequencer;
  localparam int DW  = 25;
  localparam int IW  = 10;
  localparam int WPF = 4;
  localparam int NF  = 2;
  localparam int FD  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, write, load_next_file, busy, done;
  logic [DW-1:0] data_out;
  logic [IW-1:0] index;
  logic [2:0]    state_dbg;

  output_sequencer #(
    .DATA_W(DW), .IDX_W(IW), .WORDS_PER_FILE(WPF), .NUM_FILES(NF), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .write(write), .data_out(data_out), .index(index),
    .load_next_file(load_next_file), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [DW-1:0] wr_q[$];
  int            wr_cyc_q[$];
  int            lnf_cyc_q[$];
  logic [IW-1:0] lnf_idx_q[$];
  int            hs_cyc_q[$];
  logic [DW-1:0] exp_q[$];
  int done_cnt = 0, done_cyc = 0, overlap_cnt = 0;
  int n_checks = 0, n_fail = 0;

  always @(negedge clk) begin
    if (write) begin wr_q.push_back(data_out); wr_cyc_q.push_back(cyc); end
    if (load_next_file) begin lnf_idx_q.push_back(index); lnf_cyc_q.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (write && load_next_file) overlap_cnt++;
    if (in_valid && in_ready) hs_cyc_q.push_back(cyc);
  end

  task automatic clear_logs();
    wr_q.delete(); wr_cyc_q.delete(); lnf_cyc_q.delete(); lnf_idx_q.delete();
    hs_cyc_q.delete(); exp_q.delete(); done_cnt = 0;
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic tick_mon();
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    idle(2);
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    align();
    start = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bit ok = 0;
    in_valid = 1'b1; in_data = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      align();
    end
    in_valid = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL push_timeout word=%0h got=not_accepted exp=accepted", d); end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick_mon();
    n_checks++;
    if (done_cnt == 0) begin n_fail++; $display("FAIL done_timeout got=0 exp=1 pulse"); end
    tick_mon();
    align();
  endtask

  task automatic check_writes(input string name);
    n_checks++;
    if (wr_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s_count got=%0d exp=%0d", name, wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (wr_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL %s_word%0d got=%0h exp=%0h", name, i, wr_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_data = 25'h1234;
    idle(2);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low got=%0b exp=0", in_ready); end
    in_valid = 1'b0; rst = 1'b1;
    tick_mon();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write got=%0b exp=0", write); end
    n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data_out got=%0h exp=0", data_out); end
    n_checks++; if (index !== '0) begin n_fail++; $display("FAIL reset_index got=%0h exp=0", index); end
    n_checks++; if (load_next_file !== 1'b0) begin n_fail++; $display("FAIL reset_lnf got=%0b exp=0", load_next_file); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
    n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    align();
  endtask

  task automatic test_basic();
    do_reset();
    for (int d = 1; d <= 8; d++) push_word(DW'(d));
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_full got=%0b exp=0", in_ready); end
    pulse_start();
    wait_done(80);
    for (int d = 1; d <= 8; d++) exp_q.push_back(DW'(d));
    check_writes("basic");
    n_checks++;
    if (lnf_idx_q.size() != 2) begin n_fail++; $display("FAIL basic_lnf_count got=%0d exp=2", lnf_idx_q.size()); end
    else if (lnf_idx_q[0] !== 0 || lnf_idx_q[1] !== 1) begin
      n_fail++; $display("FAIL basic_lnf_index got=%0d,%0d exp=0,1", lnf_idx_q[0], lnf_idx_q[1]);
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got=%0b exp=0", busy); end
    n_checks++; if (index !== IW'(1)) begin n_fail++; $display("FAIL basic_index_hold got=%0d exp=1", index); end
    if (wr_cyc_q.size() == 8 && lnf_cyc_q.size() == 2) begin
      n_checks++; if (wr_cyc_q[1] - wr_cyc_q[0] != 1) begin n_fail++; $display("FAIL basic_b2b got=%0d exp=1", wr_cyc_q[1] - wr_cyc_q[0]); end
      n_checks++; if (wr_cyc_q[4] - wr_cyc_q[3] != 3) begin n_fail++; $display("FAIL basic_file_gap got=%0d exp=3", wr_cyc_q[4] - wr_cyc_q[3]); end
      n_checks++; if (lnf_cyc_q[1] - wr_cyc_q[3] != 1) begin n_fail++; $display("FAIL basic_lnf_pos got=%0d exp=1", lnf_cyc_q[1] - wr_cyc_q[3]); end
      n_checks++; if (wr_cyc_q[0] - lnf_cyc_q[0] != 2) begin n_fail++; $display("FAIL basic_first_write got=%0d exp=2", wr_cyc_q[0] - lnf_cyc_q[0]); end
      n_checks++; if (done_cyc - wr_cyc_q[7] != 1) begin n_fail++; $display("FAIL basic_done_pos got=%0d exp=1", done_cyc - wr_cyc_q[7]); end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int ready_back = -1;
    do_reset();
    in_valid = 1'b1; in_data = DW'(11);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (in_ready) acc++;
      align();
      in_data = DW'(11 + acc);
    end
    n_checks++; if (acc != 8) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=8", acc); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low got=%0b exp=0", in_ready); end
    start = 1'b1;
    for (int i = 0; i < 60 && acc < 10; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (ready_back < 0) ready_back = cyc;
        acc++;
      end
      align();
      start = 1'b0;
      in_data = DW'(11 + acc);
    end
    in_valid = 1'b0; start = 1'b0;
    n_checks++; if (acc != 10) begin n_fail++; $display("FAIL bp_all_accepted got=%0d exp=10", acc); end
    wait_done(80);
    for (int d = 11; d <= 18; d++) exp_q.push_back(DW'(d));
    check_writes("bp");
    n_checks++;
    if (wr_cyc_q.size() == 0 || wr_cyc_q[0] != ready_back) begin
      n_fail++; $display("FAIL bp_ready_return got=%0d exp=first_write_cycle", ready_back);
    end
    clear_logs();
    for (int d = 21; d <= 26; d++) push_word(DW'(d));
    pulse_start();
    wait_done(80);
    for (int d = 19; d <= 26; d++) exp_q.push_back(DW'(d));
    check_writes("bp_leftover");
  endtask

  task automatic test_trickle();
    do_reset();
    pulse_start();
    idle(3);
    for (int k = 0; k < 8; k++) begin
      push_word(DW'(101 + k));
      idle(2);
    end
    wait_done(60);
    for (int k = 0; k < 8; k++) exp_q.push_back(DW'(101 + k));
    check_writes("trickle");
    if (wr_cyc_q.size() == 8 && hs_cyc_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (wr_cyc_q[i] - hs_cyc_q[i] < 2) begin
          n_fail++; $display("FAIL trickle_latency%0d got=%0d exp>=2", i, wr_cyc_q[i] - hs_cyc_q[i]);
        end
      end
      n_checks++; if (wr_cyc_q[1] - wr_cyc_q[0] != 3) begin n_fail++; $display("FAIL trickle_gap got=%0d exp=3", wr_cyc_q[1] - wr_cyc_q[0]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int d = 31; d <= 38; d++) push_word(DW'(d));
    pulse_start();
    for (int i = 0; i < 40 && wr_q.size() < 2; i++) tick_mon();
    rst = 1'b0;
    align();
    n_checks++; if (wr_q.size() != 2) begin n_fail++; $display("FAIL rmid_writes got=%0d exp=2", wr_q.size()); end
    n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL rmid_write got=%0b exp=0", write); end
    n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL rmid_data_out got=%0h exp=0", data_out); end
    n_checks++; if (index !== '0) begin n_fail++; $display("FAIL rmid_index got=%0h exp=0", index); end
    n_checks++; if (load_next_file !== 1'b0) begin n_fail++; $display("FAIL rmid_lnf got=%0b exp=0", load_next_file); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done got=%0b exp=0", done); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready got=%0b exp=0", in_ready); end
    rst = 1'b1;
    align();
    clear_logs();
    pulse_start();
    idle(15);
    n_checks++;
    if (lnf_idx_q.size() != 1 || lnf_idx_q[0] !== '0) begin
      n_fail++; $display("FAIL rmid_reopen got=%0d_pulses exp=1_pulse_index0", lnf_idx_q.size());
    end
    n_checks++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL rmid_fifo_empty got=%0d_writes exp=0", wr_q.size()); end
    n_checks++; if (state_dbg !== 3'd2) begin n_fail++; $display("FAIL rmid_state got=%0d exp=2", state_dbg); end
  endtask

  task automatic test_start_ignored();
    do_reset();
    for (int d = 41; d <= 43; d++) push_word(DW'(d));
    pulse_start();
    for (int i = 0; i < 40 && wr_q.size() < 3; i++) tick_mon();
    align();
    idle(2);
    pulse_start();
    idle(1);
    pulse_start();
    idle(2);
    n_checks++; if (index !== '0) begin n_fail++; $display("FAIL sig_index got=%0d exp=0", index); end
    n_checks++; if (lnf_idx_q.size() != 1) begin n_fail++; $display("FAIL sig_lnf got=%0d exp=1", lnf_idx_q.size()); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL sig_done got=%0d exp=0", done_cnt); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sig_busy got=%0b exp=1", busy); end
    n_checks++; if (state_dbg !== 3'd2) begin n_fail++; $display("FAIL sig_state got=%0d exp=2", state_dbg); end
    for (int d = 44; d <= 48; d++) push_word(DW'(d));
    wait_done(60);
    for (int d = 41; d <= 48; d++) exp_q.push_back(DW'(d));
    check_writes("sig");
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL sig_done_final got=%0d exp=1", done_cnt); end
    n_checks++;
    if (lnf_cyc_q.size() != 2 || wr_cyc_q.size() != 8) begin
      n_fail++; $display("FAIL sig_boundary got=%0d_lnf exp=2", lnf_cyc_q.size());
    end else if (!(lnf_cyc_q[1] > wr_cyc_q[3] && lnf_cyc_q[1] < wr_cyc_q[4])) begin
      n_fail++; $display("FAIL sig_boundary got=lnf@%0d exp=between %0d and %0d", lnf_cyc_q[1], wr_cyc_q[3], wr_cyc_q[4]);
    end
  endtask

`ifdef OUT_CHECKSUM_EN
  task automatic test_checksum();
    logic [DW-1:0] words[8];
    words = '{25'h1, 25'h2, 25'h4, 25'h8, 25'h3, 25'h5, 25'h6, 25'h9};
    do_reset();
    for (int i = 0; i < 8; i++) push_word(words[i]);
    pulse_start();
    wait_done(80);
    for (int i = 0; i < 4; i++) exp_q.push_back(words[i]);
    exp_q.push_back(25'hF);
    for (int i = 4; i < 8; i++) exp_q.push_back(words[i]);
    exp_q.push_back(25'h9);
    check_writes("csum");
    n_checks++;
    if (wr_cyc_q.size() != 10 || wr_cyc_q[4] - wr_cyc_q[3] != 1) begin
      n_fail++; $display("FAIL csum_position got=%0d_writes exp=10 with csum adjacent", wr_cyc_q.size());
    end
  endtask
`endif

  task automatic test_invariants();
    n_checks++;
    if (overlap_cnt != 0) begin n_fail++; $display("FAIL write_lnf_overlap got=%0d exp=0", overlap_cnt); end
  endtask

  initial begin
    idle(1);
    test_reset();
    test_basic();
    test_backpressure();
    test_trickle();
    test_reset_mid();
    test_start_ignored();
`ifdef OUT_CHECKSUM_EN
    test_checksum();
`endif
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
